// File: rtl/ram_2port_sync_be.sv
// ram_2port_sync_be: single-clock RAM with a byte-enabled write port, a read port,
// selectable read-during-write policy, optional output register and post-reset clear sweep.
module ram_2port_sync_be #(
  parameter int DATA_WIDTH = 32,
  parameter int LENGTH = 1536,
  parameter int ADDR_WIDTH = 32,
  parameter bit RDW_NEW = 1,
  parameter bit OUT_REG = 0,
  parameter bit CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   w_addr,
  input  logic [DATA_WIDTH-1:0]   wd,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   r_addr,
  output logic [DATA_WIDTH-1:0]   rd,
  output logic                    rd_valid,
  output logic                    busy
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = LENGTH > 1 ? $clog2(LENGTH) : 1;
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] mem [LENGTH];
  logic [IW-1:0] clr_cnt, m_idx;
  logic [NB-1:0] m_be;
  logic [DATA_WIDTH-1:0] m_d, old_r, merged, r_data, s1_d;
  logic w_ok, r_ok, wen, r_go, s1_v, done;
  always_comb begin
    w_ok = w_addr < ADDR_WIDTH'(LENGTH);
    r_ok = r_addr < ADDR_WIDTH'(LENGTH);
    r_go = state == IDLE && re;
    wen = !rst && (state == CLEAR || (we && w_ok));
    m_idx = state == CLEAR ? clr_cnt : w_addr[IW-1:0];
    m_be = state == CLEAR ? '1 : wbe;
    m_d = state == CLEAR ? CLEAR_VALUE : wd;
    old_r = mem[r_addr[IW-1:0]];
    merged = old_r;
    for (int i = 0; i < NB; i++)
      merged[8*i+:8] = wbe[i] ? wd[8*i+:8] : old_r[8*i+:8];
    r_data = !r_ok ? '0 : (RDW_NEW && we && w_addr == r_addr) ? merged : old_r;
    done = OUT_REG ? s1_v : r_go;
  end
  always_ff @(posedge clk)
    for (int i = 0; i < NB; i++)
      if (wen && m_be[i]) mem[m_idx][8*i+:8] <= m_d[8*i+:8];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR_ON_RESET ? CLEAR : IDLE;
      busy <= CLEAR_ON_RESET;
      clr_cnt <= '0;
      s1_v <= 1'b0;
      s1_d <= '0;
      rd_valid <= 1'b0;
      rd <= '0;
    end else begin
      if (state == CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == IW'(LENGTH - 1)) begin
          state <= IDLE;
          busy <= 1'b0;
        end
      end
      s1_v <= r_go;
      if (r_go) s1_d <= r_data;
      rd_valid <= done;
      if (done) rd <= OUT_REG ? s1_d : r_data;
    end
  end
endmodule

// File: tb/tb_ram_2port_sync_be.sv
// tb_ram_2port_sync_be: drives two RAM configurations (new-data/no-outreg and old-data/outreg)
// with shared stimulus and checks them against an array-based reference model.
module tb_ram_2port_sync_be;
  localparam int L = 16;
  localparam logic [31:0] CV = 32'hDEADBEEF;
  logic clk = 0, rst = 1, we = 0, re = 0;
  logic [31:0] w_addr = 0, r_addr = 0, wd = 0;
  logic [3:0] wbe = 0;
  logic [31:0] rd_a, rd_b;
  logic rv_a, rv_b, busy_a, busy_b;
  always #5 clk = ~clk;
  ram_2port_sync_be #(.DATA_WIDTH(32), .LENGTH(L), .ADDR_WIDTH(32), .RDW_NEW(1), .OUT_REG(0),
    .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)) dut_a (.clk(clk), .rst(rst), .we(we), .w_addr(w_addr),
    .wd(wd), .wbe(wbe), .re(re), .r_addr(r_addr), .rd(rd_a), .rd_valid(rv_a), .busy(busy_a));
  ram_2port_sync_be #(.DATA_WIDTH(32), .LENGTH(L), .ADDR_WIDTH(32), .RDW_NEW(0), .OUT_REG(1),
    .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)) dut_b (.clk(clk), .rst(rst), .we(we), .w_addr(w_addr),
    .wd(wd), .wbe(wbe), .re(re), .r_addr(r_addr), .rd(rd_b), .rd_valid(rv_b), .busy(busy_b));
  int checks = 0, errors = 0;
  logic [31:0] m [L];
  int clr_left = 0;
  logic e_busy = 1, e_va = 0, e_vb = 0, p_v = 0;
  logic [31:0] e_rda = 0, e_rdb = 0, p_d = 0;
  typedef struct {
    logic w; logic [31:0] wa; logic [31:0] d; logic [3:0] be;
    logic r; logic [31:0] ra; logic [31:0] xa; logic [31:0] xb;
  } vec_t;
  vec_t tbl [11];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (o & ~mask) | (d & mask);
  endfunction
  task automatic model();
    logic [31:0] old, nw;
    if (rst) begin
      e_busy = 1; clr_left = L; e_va = 0; e_vb = 0; p_v = 0; e_rda = 0; e_rdb = 0;
    end else begin
      e_vb = p_v;
      if (p_v) e_rdb = p_d;
      if (e_busy) begin
        m[L - clr_left] = CV;
        clr_left--;
        e_busy = clr_left > 0;
        p_v = 0; e_va = 0;
      end else begin
        old = r_addr < L ? m[r_addr] : 32'h0;
        nw = (we && w_addr == r_addr && r_addr < L) ? merge(old, wd, wbe) : old;
        e_va = re;
        if (re) e_rda = nw;
        p_v = re; p_d = old;
        if (we && w_addr < L) m[w_addr] = merge(m[w_addr], wd, wbe);
      end
    end
  endtask
  task automatic step(input logic r, input logic w, input logic [31:0] wa, input logic [31:0] d,
                      input logic [3:0] be, input logic rr, input logic [31:0] ra);
    rst = r; we = w; w_addr = wa; wd = d; wbe = be; re = rr; r_addr = ra;
    @(posedge clk);
    model();
    #1;
    chk("busy_a", busy_a, e_busy);
    chk("busy_b", busy_b, e_busy);
    chk("rv_a", rv_a, e_va);
    chk("rv_b", rv_b, e_vb);
    chk("rd_a", rd_a, e_rda);
    chk("rd_b", rd_b, e_rdb);
  endtask
  task automatic count_busy(input string name);
    int n = 0;
    while (busy_a && n < 40) begin
      n++;
      step(0, 1, 32'd3, 32'h5555AAAA, 4'hF, 1, 32'd3);
    end
    chk(name, n, 16);
  endtask
  initial begin
    tbl = '{
      '{1, 5, 32'h11223344, 4'hF, 0, 0, 0, 0},
      '{1, 5, 32'hAABBCCDD, 4'b0101, 0, 0, 0, 0},
      '{0, 0, 0, 4'h0, 1, 5, 32'h11BB33DD, 32'h11BB33DD},
      '{1, 7, 32'h0, 4'hF, 0, 0, 0, 0},
      '{1, 7, 32'hCAFEF00D, 4'hF, 1, 7, 32'hCAFEF00D, 32'h0},
      '{0, 0, 0, 4'h0, 1, 7, 32'hCAFEF00D, 32'hCAFEF00D},
      '{1, 16, 32'h12345678, 4'hF, 0, 0, 0, 0},
      '{0, 0, 0, 4'h0, 1, 16, 32'h0, 32'h0},
      '{0, 0, 0, 4'h0, 1, 0, CV, CV},
      '{1, 5, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 0},
      '{0, 0, 0, 4'h0, 1, 5, 32'h11BB33DD, 32'h11BB33DD}
    };
    step(1, 0, 0, 0, 0, 0, 0);
    count_busy("clear_len");
    for (int a = 0; a < L; a++) begin
      step(0, 0, 0, 0, 0, 1, a);
      chk("clr_rv", rv_a, 1);
      chk("clr_data", rd_a, CV);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      step(0, tbl[i].w, tbl[i].wa, tbl[i].d, tbl[i].be, tbl[i].r, tbl[i].ra);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      if (tbl[i].r) begin
        chk("tbl_a", rd_a, tbl[i].xa);
        chk("tbl_b", rd_b, tbl[i].xb);
      end
    end
    step(0, 1, 1, 32'h11111111, 4'hF, 0, 0);
    step(0, 1, 2, 32'h22222222, 4'hF, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("lat_n1", rv_b, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    chk("lat_n2_v", rv_b, 1);
    chk("lat_n2_d", rd_b, CV);
    step(0, 0, 0, 0, 0, 1, 2);
    chk("lat_n3_d", rd_b, 32'h11111111);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("lat_n4_v", rv_b, 1);
    chk("lat_n4_d", rd_b, 32'h22222222);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("hold_v", rv_b, 0);
    chk("hold_d", rd_b, 32'h22222222);
    step(0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("flight_drop", rv_b, 0);
    for (int c = 0; c < 8; c++) step(0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    count_busy("restart_len");
    for (int c = 0; c < 400; c++)
      step(0, 1'($urandom), 32'($urandom_range(0, 17)), $urandom, 4'($urandom),
           1'($urandom), 32'($urandom_range(0, 17)));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_2port_sync_be.md
# ram_2port_sync_be

Single-clock, parametrised dual-port RAM: one write port with per-byte enables, one read port. Supersedes the dual-clock 1rd1wr RAM in single-clock-domain parts of the design (framebuffer/scratch memories). Adds a selectable read-during-write policy, an optional output register, a read-valid strobe, and a hardware clear sweep after reset.

## Interface

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- LENGTH, 1536, number of words.
- ADDR_WIDTH, 32, address port width; addresses >= LENGTH are out of range.
- RDW_NEW, 1, same-address read during write: 1 returns the merged new word, 0 returns the old word.
- OUT_REG, 0, 1 adds an output pipeline register (read latency 2 instead of 1).
- CLEAR_ON_RESET, 1, 1 runs the clear sweep after reset.
- CLEAR_VALUE, 0, word value written by the clear sweep.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- we  in  1  write request.
- w_addr  in  ADDR_WIDTH  write address.
- wd  in  DATA_WIDTH  write data.
- wbe  in  DATA_WIDTH/8  byte enables; bit i covers wd[8i+7:8i].
- re  in  1  read request.
- r_addr  in  ADDR_WIDTH  read address.
- rd  out  DATA_WIDTH  read data.
- rd_valid  out  1  one-cycle strobe; rd holds valid data when this is high.
- busy  out  1  clear sweep in progress; requests are ignored.

## Operation

- FSM states: CLEAR, IDLE.
  - rst high: enter CLEAR (CLEAR_ON_RESET=1) or IDLE (CLEAR_ON_RESET=0).
  - CLEAR → IDLE after word LENGTH-1 is written.
- Reset values: rd=0, rd_valid=0, pipeline valid bits=0, clear counter=0.
  - busy=1 if CLEAR_ON_RESET=1, else 0.
- CLEAR state:
  - Each cycle with rst low writes CLEAR_VALUE to word clr_cnt and increments clr_cnt.
  - we and re are ignored; no rd_valid is produced.
- IDLE, write: with we=1 and w_addr<LENGTH, byte lane i of the word is updated iff wbe[i]=1.
  - wbe=0 writes nothing.
  - Out-of-range write is dropped; memory is unchanged.
- IDLE, read: re=1 launches a read of r_addr.
  - Out-of-range read returns 0 and still strobes rd_valid.
- Same-address read and write in the same cycle:
  - RDW_NEW=1: return the old word with the enabled lanes replaced by wd.
  - RDW_NEW=0: return the old word.
  - Memory is updated in both cases.
- rd holds its last value when no read completes; only rd_valid pulses.
- Reads and writes to different addresses are fully independent. Back-to-back reads are accepted every cycle (full throughput).

## Timing

- Read latency, request in cycle N:
  - OUT_REG=0: rd and rd_valid in cycle N+1.
  - OUT_REG=1: rd and rd_valid in cycle N+2.
- Write in cycle N, read of the same address in cycle N+1 or later: returns the written data.
- Clear duration, counting cycle 1 as the first cycle with rst low:
  - Cycles 1..LENGTH clear words 0..LENGTH-1; busy=1 through cycle LENGTH.
  - busy=0 from cycle LENGTH+1, which is the first cycle a request is accepted.
- Reset mid-sweep: clr_cnt returns to 0 and the sweep restarts from word 0 after rst falls.
- Reset with reads in flight: the in-flight reads are discarded and no rd_valid is produced.
- Held rst: the FSM stays in its reset state and no words are cleared while rst=1.

## Test plan

- Clear sweep, LENGTH=16, CLEAR_VALUE=32'hDEADBEEF: pulse rst for 1 cycle → busy=1 for exactly 16 cycles. Then reading addresses 0..15 returns 32'hDEADBEEF, each with rd_valid 1 cycle after re.
- Byte enables: write 32'h11223344 to addr 5 with wbe=4'hF, then 32'hAABBCCDD with wbe=4'b0101 → read of addr 5 returns 32'h11BB33DD.
- Read-during-write: addr 7 holds 32'h0, then same-cycle write 32'hCAFEF00D (wbe=4'hF) and read of addr 7.
  - RDW_NEW=1 → rd=32'hCAFEF00D.
  - RDW_NEW=0 → rd=32'h0.
  - A read of addr 7 on the next cycle returns 32'hCAFEF00D under both settings.
- Latency/throughput, OUT_REG=1: reads of addrs 0,1,2 in consecutive cycles N..N+2 → rd_valid high in N+2..N+4 with data in order, and rd unchanged afterwards.
- Out-of-range: write to addr 16 (LENGTH=16), then read of addr 16 → rd=0 with rd_valid; addr 0 contents are unchanged.
- Reset mid-sweep: assert rst at clear cycle 9 → sweep restarts, busy stays high for 16 more cycles after rst falls, and a re during busy produces no rd_valid.
